// File: rtl/vga_ctrl.sv
// vga_ctrl -- VGA scan timing generator and pixel output stage.
//
// The block sits directly downstream of the framebuffer. Its scan counters
// produce h_addr/v_addr. The framebuffer returns vga_data RD_LATENCY clocks
// later. The blanking and sync flags are delayed by the same amount, so each
// pixel leaves on the same clock as its syncs.
//
// Optional build macro: VGA_TEST_PATTERN_EN. When it is defined, pattern_en=1
// replaces vga_data with 8 vertical colour bars (bar 0 black .. bar 7 white).
// When it is undefined, pattern_en is ignored and no pattern logic exists.
//
// Ports:
//   clock        pixel clock; all state changes on its rising edge
//   reset        asynchronous reset, active low
//   h_addr/v_addr  scan coordinate to the framebuffer (0 outside active area)
//   vga_data     {R,G,B} 4:4:4 from the framebuffer, RD_LATENCY clocks after its address
//   vga_r/g/b    pixel pins (zero while blanked)
//   vga_hs/vga_vs  active-low syncs, aligned with the pixel pins
//   valid        high while vga_r/g/b carry a visible pixel
//   frame_start  high while the scan sits at (0,0), at the address stage
//   pattern_en   selects the test pattern (only with VGA_TEST_PATTERN_EN)
//
// H_TOTAL and V_TOTAL must not exceed 1024. RD_LATENCY must be in 1..4.
// The pattern build also needs H_ACTIVE >= 8.
module vga_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int RD_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    input  logic [11:0] vga_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        valid,
    output logic        frame_start,
    input  logic        pattern_en
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Region bounds are 11 bits wide. The sync end can equal the total,
    // and the total may reach 1024.
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // ---------------- address stage ----------------
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       h_wrap, v_wrap;
    logic       h_act, v_act, h_sync, v_sync;
    logic       act, hs_n, vs_n;

    always_comb begin
        h_wrap  = ({1'b0, h_cnt_q} == H_LAST);
        v_wrap  = ({1'b0, v_cnt_q} == V_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        // The line counter advances only when the pixel counter wraps.
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
        end
    end

    always_comb begin
        h_act       = ({1'b0, h_cnt_q} < H_ACT);
        v_act       = ({1'b0, v_cnt_q} < V_ACT);
        h_sync      = ({1'b0, h_cnt_q} >= H_SS) && ({1'b0, h_cnt_q} < H_SE);
        v_sync      = ({1'b0, v_cnt_q} >= V_SS) && ({1'b0, v_cnt_q} < V_SE);
        act         = h_act && v_act;
        hs_n        = !h_sync;
        vs_n        = !v_sync;
        h_addr      = h_act ? h_cnt_q : '0;
        v_addr      = v_act ? v_cnt_q : '0;
        frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // ---------------- read-latency alignment ----------------
    // Bit 0 is one clock behind the address stage. Bit RD_LATENCY-1 lines up
    // with the vga_data returned for that address.
    logic [RD_LATENCY-1:0] act_pipe_q, act_pipe_d;
    logic [RD_LATENCY-1:0] hs_pipe_q,  hs_pipe_d;
    logic [RD_LATENCY-1:0] vs_pipe_q,  vs_pipe_d;

    always_comb begin
        act_pipe_d = (RD_LATENCY)'({act_pipe_q, act});
        hs_pipe_d  = (RD_LATENCY)'({hs_pipe_q, hs_n});
        vs_pipe_d  = (RD_LATENCY)'({vs_pipe_q, vs_n});
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            act_pipe_q <= '0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            act_pipe_q <= act_pipe_d;
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
        end
    end

    // ---------------- pixel source ----------------
    logic [11:0] src_pix;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

    logic [2:0]                   bar_idx;
    logic [11:0]                  pat_pix;
    logic [RD_LATENCY-1:0][11:0]  pat_pipe_q, pat_pipe_d;

    // The pattern is produced from h_addr and delayed like a framebuffer read.
    // That keeps the bar edges on the same columns as the real data.
    always_comb begin
        bar_idx    = 3'(h_addr / BAR_W);
        pat_pix    = {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}};
        pat_pipe_d = (RD_LATENCY * 12)'({pat_pipe_q, pat_pix});
        src_pix    = pattern_en ? pat_pipe_q[RD_LATENCY-1] : vga_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pat_pipe_q <= '0;
        end else begin
            pat_pipe_q <= pat_pipe_d;
        end
    end
`else
    logic pattern_en_unused;

    assign pattern_en_unused = pattern_en;

    always_comb begin
        src_pix = vga_data;
    end
`endif

    // ---------------- output stage ----------------
    // vga_data is already registered in the framebuffer. Gating it here keeps
    // the pixel on the same clock as the delayed flags.
    always_comb begin
        valid                   = act_pipe_q[RD_LATENCY-1];
        vga_hs                  = hs_pipe_q[RD_LATENCY-1];
        vga_vs                  = vs_pipe_q[RD_LATENCY-1];
        {vga_r, vga_g, vga_b}   = valid ? src_pix : 12'h000;
    end

endmodule

// File: tb/tb_vga_ctrl.sv
module tb_vga_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pattern_en = 1'b0;

    always #5 clk = ~clk;

`ifdef VGA_TEST_PATTERN_EN
    localparam bit PAT_BUILD = 1'b1;
`else
    localparam bit PAT_BUILD = 1'b0;
`endif

    // Three instances are used. Instance 0 has default timing and latency 1.
    // Instances 1 and 2 share a small timing set and differ only in latency
    // (1 and 3), so whole frames stay short.
    localparam int P_HA [3] = '{640, 16, 16};
    localparam int P_HF [3] = '{16, 2, 2};
    localparam int P_HS [3] = '{96, 3, 3};
    localparam int P_HB [3] = '{48, 3, 3};
    localparam int P_VA [3] = '{480, 8, 8};
    localparam int P_VF [3] = '{10, 1, 1};
    localparam int P_VS [3] = '{2, 2, 2};
    localparam int P_VB [3] = '{33, 2, 2};
    localparam int P_L  [3] = '{1, 1, 3};

    logic [9:0]  o_ha [3];
    logic [9:0]  o_va [3];
    logic [11:0] o_rgb [3];
    logic        o_vld [3];
    logic        o_hs [3];
    logic        o_vs [3];
    logic        o_fs [3];
    logic [3:0]  r [3];
    logic [3:0]  g [3];
    logic [3:0]  b [3];

    // Framebuffer models return {x[3:0], y[3:0], 4'h5}.
    logic [11:0] fb_d, fb_a, fb_b0, fb_b1, fb_b2;

    always @(posedge clk) begin
        fb_d  <= {o_ha[0][3:0], o_va[0][3:0], 4'h5};
        fb_a  <= {o_ha[1][3:0], o_va[1][3:0], 4'h5};
        fb_b0 <= {o_ha[2][3:0], o_va[2][3:0], 4'h5};
        fb_b1 <= fb_b0;
        fb_b2 <= fb_b1;
    end

    vga_ctrl u_d (
        .clock(clk), .reset(rst_n), .h_addr(o_ha[0]), .v_addr(o_va[0]), .vga_data(fb_d),
        .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]), .vga_hs(o_hs[0]), .vga_vs(o_vs[0]),
        .valid(o_vld[0]), .frame_start(o_fs[0]), .pattern_en(pattern_en));

    vga_ctrl #(.H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3), .V_ACTIVE(8),
               .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .RD_LATENCY(1)) u_a (
        .clock(clk), .reset(rst_n), .h_addr(o_ha[1]), .v_addr(o_va[1]), .vga_data(fb_a),
        .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]), .vga_hs(o_hs[1]), .vga_vs(o_vs[1]),
        .valid(o_vld[1]), .frame_start(o_fs[1]), .pattern_en(pattern_en));

    vga_ctrl #(.H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3), .V_ACTIVE(8),
               .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .RD_LATENCY(3)) u_b (
        .clock(clk), .reset(rst_n), .h_addr(o_ha[2]), .v_addr(o_va[2]), .vga_data(fb_b2),
        .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]), .vga_hs(o_hs[2]), .vga_vs(o_vs[2]),
        .valid(o_vld[2]), .frame_start(o_fs[2]), .pattern_en(pattern_en));

    assign o_rgb[0] = {r[0], g[0], b[0]};
    assign o_rgb[1] = {r[1], g[1], b[1]};
    assign o_rgb[2] = {r[2], g[2], b[2]};

    typedef struct packed {
        logic        vld;
        logic        hs;
        logic        vs;
        logic [11:0] fb;
        logic [11:0] pat;
        logic [9:0]  x;
        logic [9:0]  y;
    } exp_t;

    localparam exp_t RST_E = '{vld: 1'b0, hs: 1'b1, vs: 1'b1, fb: 12'h0, pat: 12'h0,
                               x: 10'h3FF, y: 10'h3FF};

    exp_t        sbq [3][$];
    logic [14:0] hist [$];
    int          mx [3];
    int          my [3];
    int          n_pass = 0;
    int          n_tot = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_fs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tot++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, want, cyc);
        end
    endtask

    // Expected pin values for scan count (x,y) of instance id.
    function automatic exp_t mdl(int id, int x, int y);
        exp_t e;
        int   hs0, vs0;
        logic [2:0] bar;
        hs0   = P_HA[id] + P_HF[id];
        vs0   = P_VA[id] + P_VF[id];
        e.vld = (x < P_HA[id]) && (y < P_VA[id]);
        e.hs  = !(x >= hs0 && x < hs0 + P_HS[id]);
        e.vs  = !(y >= vs0 && y < vs0 + P_VS[id]);
        e.fb  = {4'(x), 4'(y), 4'h5};
        bar   = 3'(x / (P_HA[id] / 8));
        e.pat = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
        e.x   = 10'(x);
        e.y   = 10'(y);
        return e;
    endfunction

    task automatic chk_rst(input int id);
        chk("rst_h_addr", 32'(o_ha[id]), 32'd0);
        chk("rst_v_addr", 32'(o_va[id]), 32'd0);
        chk("rst_frame_start", 32'(o_fs[id]), 32'd1);
        chk("rst_valid", 32'(o_vld[id]), 32'd0);
        chk("rst_hs", 32'(o_hs[id]), 32'd1);
        chk("rst_vs", 32'(o_vs[id]), 32'd1);
        chk("rst_rgb", 32'(o_rgb[id]), 32'd0);
    endtask

    // Count (0,0) is already on the counters when reset releases. Its flags
    // reach the pins after RD_LATENCY clocks; until then the pins hold reset values.
    task automatic release_rst();
        rst_n = 1'b1;
        for (int id = 0; id < 3; id++) begin
            sbq[id].delete();
            for (int k = 1; k < P_L[id]; k++) sbq[id].push_back(RST_E);
            sbq[id].push_back(mdl(id, 0, 0));
            mx[id] = 1;
            my[id] = 0;
        end
        last_fs = cyc;
    endtask

    task automatic step();
        exp_t        e;
        logic [11:0] rgb_want;
        logic        pat_on;
        int          ht, vt;
        @(negedge clk);
        cyc++;
        pat_on = PAT_BUILD && pattern_en;
        for (int id = 0; id < 3; id++) begin
            if (!rst_n) begin
                chk_rst(id);
            end else begin
                chk("h_addr", 32'(o_ha[id]), (mx[id] < P_HA[id]) ? mx[id] : 0);
                chk("v_addr", 32'(o_va[id]), (my[id] < P_VA[id]) ? my[id] : 0);
                chk("frame_start", 32'(o_fs[id]), 32'(mx[id] == 0 && my[id] == 0));
                if (id == 1 && o_fs[1]) begin
                    chk("frame_period", cyc - last_fs, 312);
                    last_fs = cyc;
                end
                sbq[id].push_back(mdl(id, mx[id], my[id]));
                e = sbq[id].pop_front();
                chk("valid", 32'(o_vld[id]), 32'(e.vld));
                chk("hs", 32'(o_hs[id]), 32'(e.hs));
                chk("vs", 32'(o_vs[id]), 32'(e.vs));
                rgb_want = !e.vld ? 12'h000 : (pat_on ? e.pat : e.fb);
                chk("rgb", 32'(o_rgb[id]), 32'(rgb_want));
                if (id == 1 && e.vld && e.x == 10'd3 && e.y == 10'd2 && !pat_on)
                    chk("pixel_3_2", 32'(o_rgb[1]), 32'h325);
                if (id == 0 && pat_on && e.y == 10'd0 &&
                    (e.x == 10'd0 || e.x == 10'd85 || e.x == 10'd639))
                    chk("pattern_bar", 32'(o_rgb[0]),
                        (e.x == 10'd0) ? 32'h000 : (e.x == 10'd85) ? 32'h00F : 32'hFFF);
                ht = P_HA[id] + P_HF[id] + P_HS[id] + P_HB[id];
                vt = P_VA[id] + P_VF[id] + P_VS[id] + P_VB[id];
                mx[id]++;
                if (mx[id] == ht) begin
                    mx[id] = 0;
                    my[id]++;
                    if (my[id] == vt) my[id] = 0;
                end
            end
        end
        // Latency 3 must look exactly like latency 1 shifted two clocks later.
        hist.push_back({o_vld[1], o_hs[1], o_vs[1], o_rgb[1]});
        if (hist.size() > 2)
            chk("lat3_vs_lat1", 32'({o_vld[2], o_hs[2], o_vs[2], o_rgb[2]}), 32'(hist.pop_front()));
    endtask

    initial begin
        // Instance 0 runs line 0 with the pattern selected when the pattern
        // build is active. The switch back to framebuffer data comes later.
        pattern_en = 1'b1;
        rst_n = 1'b0;
        repeat (5) step();
        release_rst();
        repeat (1000) step();
        pattern_en = 1'b0;
        hist.delete();
        repeat (1200) step();

        // Asynchronous reset part-way through a line.
        rst_n = 1'b0;
        #1;
        for (int id = 0; id < 3; id++) chk_rst(id);
        hist.delete();
        repeat (3) step();
        release_rst();
        repeat (400) step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/vga_ctrl.md
Name: vga_ctrl

Overview:
- VGA timing generator and pixel output stage that sits directly downstream of the framebuffer.
- Produces the h_addr/v_addr scan coordinates the framebuffer reads from.
- Takes back its registered 12-bit vga_data and drives the 4:4:4 RGB and sync pins.
- Aligns sync and blanking to the framebuffer read latency, so each pixel leaves on the same cycle as its syncs.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
RD_LATENCY, 1, framebuffer read latency in clocks (legal 1..4)

Ports:
clock  in  1  pixel clock; all state on its rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
h_addr  out  10  horizontal scan coordinate to framebuffer
v_addr  out  10  vertical scan coordinate to framebuffer
vga_data  in  12  pixel {R[11:8],G[7:4],B[3:0]} from framebuffer, RD_LATENCY clocks after its address
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
vga_hs  out  1  horizontal sync, active-low
vga_vs  out  1  vertical sync, active-low
valid  out  1  high while vga_r/g/b carry a visible pixel
frame_start  out  1  one-clock pulse at scan position (0,0), address stage
pattern_en  in  1  selects internal test pattern; only used with VGA_TEST_PATTERN_EN

Behaviour:
- H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters. Both must be ≤1024; counters are 10 bits.
- Address stage:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only on the h_cnt wrap, counts 0..V_TOTAL-1, and wraps to 0 when both counters wrap on the same clock.
- Regions, h (v identical with V parameters):
  - active: h_cnt < H_ACTIVE
  - front porch: H_ACTIVE .. H_ACTIVE+H_FRONT-1
  - sync: next H_SYNC counts
  - back porch: remaining counts
- Address outputs:
  - h_addr = h_cnt when h active, else 0; v_addr = v_cnt when v active, else 0.
  - Both are combinational from the counters, so the address is presented in the same clock as its count.
- Per-count flags: act = h active AND v active; hs_n = 0 in the h sync region; vs_n = 0 in the v sync region (for whole lines).
- frame_start = 1 exactly when h_cnt==0 && v_cnt==0. It is not delayed.
- Output stage:
  - act, hs_n and vs_n pass through a RD_LATENCY-deep shift register.
  - The outputs are registered: vga_hs/vga_vs/valid equal the flags delayed by RD_LATENCY.
  - {vga_r,vga_g,vga_b} = vga_data when the delayed act is 1, else 12'h000. The pixel for address (x,y) appears on the pins RD_LATENCY clocks after that address.
- Reset (asynchronous, active-low), applied immediately:
  - h_cnt = v_cnt = 0
  - all delay stages: act=0, hs_n=1, vs_n=1
  - vga_hs = vga_vs = 1, valid = 0, RGB = 0
  - frame_start = 1 while counters are at (0,0), i.e. during reset and the first clock after release
- Reset mid-frame aborts the scan with no partial-line recovery. After release the scan restarts at (0,0) and the first valid rises RD_LATENCY clocks later.
- Frame period is H_TOTAL*V_TOTAL clocks (800*525 = 420000 at defaults).
- No backpressure: the scan free-runs, and vga_data is sampled unconditionally.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined, pattern_en=1: vga_data is ignored. The RGB source becomes 8 vertical colour bars, each H_ACTIVE/8 wide. Bar index = h_addr/(H_ACTIVE/8). Colour = {R,G,B} each 4'hF or 4'h0 from index bits {2,1,0}, so bar 0 = black and bar 7 = white.
- The pattern value is generated at the address stage and delayed by RD_LATENCY, so alignment matches framebuffer data.
- Defined, pattern_en=0: normal behaviour.
- Undefined: pattern_en is ignored and no pattern logic is synthesized.

Test Plan:
- Hold reset=0 for 5 clocks -> vga_hs=1, vga_vs=1, valid=0, RGB=0, h_addr=v_addr=0; frame_start=1 while held.
- Release reset, defaults -> valid high at clocks 1..640, low 641..800; vga_hs low for clocks 657..752 inclusive (96 clocks); line period 800.
- Run 2 frames -> frame_start pulses exactly every 420000 clocks; vga_vs low for 1600 clocks starting on line 490; no valid during lines 480..524.
- Bench framebuffer model returns {h_addr[3:0],v_addr[3:0],4'h5} with 1-clock latency -> pixel (x=3,y=2) appears as 12'h325 on vga_r/g/b exactly when it is the 4th valid pixel of line 2; RGB = 0 whenever valid=0.
- RD_LATENCY=3 with a matching 3-clock model -> same pixel/sync alignment, all outputs shifted 2 clocks later than the RD_LATENCY=1 run.
- With VGA_TEST_PATTERN_EN and pattern_en=1 -> pixel x=0 gives 12'h000, x=85 gives 12'h00F, x=639 gives 12'hFFF; assert reset mid-line -> outputs return to reset values within the same clock.
